param_sync_fifo: RTL and testbench
==================================

Name: param_sync_fifo

Overview:
- Single-clock, parametrised successor to the fixed 8-bit dual-clock FIFO.
- Configurable width and depth, and selectable standard or first-word-fall-through (FWFT) read mode.
- Adds programmable almost_full/almost_empty thresholds, fill count, sticky overflow/underflow error flags and a synchronous flush.
- Used as the in-domain elastic buffer wherever producer and consumer share one clock.

Parameters:
- DATA_WIDTH, 8, bits per word.
- DEPTH, 16, number of entries; must be a power of 2 and at least 4.
- FWFT, 0, read mode: 0 = standard (registered read), 1 = first-word-fall-through.
- AF_LEVEL, DEPTH-2, almost_full asserts when fill_count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when fill_count <= AE_LEVEL.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of pointers, count and read_valid.
- write_enable  in  1  write request.
- write_data  in  DATA_WIDTH  write word.
- read_enable  in  1  read/pop request.
- read_data  out  DATA_WIDTH  read word.
- read_valid  out  1  read_data holds a newly popped word (standard mode) / head word is valid (FWFT mode).
- full  out  1  DEPTH entries stored.
- empty  out  1  no entries stored.
- almost_full  out  1  threshold flag.
- almost_empty  out  1  threshold flag.
- fill_count  out  ADDR_W+1  entries stored, 0..DEPTH; ADDR_W = clog2(DEPTH).
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.
- clear_errors  in  1  synchronous clear of overflow/underflow.

Behaviour:
- Reset (rst=0, asynchronous):
  - wr_ptr = 0, rd_ptr = 0, fill_count = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - read_data = 0, read_valid = 0, overflow = 0, underflow = 0.
  - Memory contents are not reset.
- Pointers are ADDR_W+1 bits; the MSB is the wrap bit.
  - full = (ptr addresses equal) && (wrap bits differ).
  - empty = (wr_ptr == rd_ptr).
  - Both flags are decoded from registered pointers, so they have no combinational path from the enables.
- Write accepted = write_enable && !full.
  - Word is stored at wr_ptr[ADDR_W-1:0] and wr_ptr increments at the edge.
- Read accepted = read_enable && !empty.
  - rd_ptr increments at the edge.
- Simultaneous accepted read and write: fill_count is unchanged, and both pointers advance.
- Write while full is rejected, even if a read is accepted the same cycle. Memory and wr_ptr are untouched and overflow is set.
- Read while empty is rejected, even if a write is accepted the same cycle. rd_ptr is untouched and underflow is set.
- fill_count: +1 on write only, -1 on read only, otherwise held. It never exceeds DEPTH or goes below 0.
- Flag latency: empty deasserts 1 cycle after the first accepted write; full asserts 1 cycle after the DEPTH-th net write.
- almost_full and almost_empty are combinational compares on the registered fill_count.
- Standard mode (FWFT=0):
  - An accepted read loads read_data from mem[rd_ptr] at the same edge; data is visible 1 cycle after read_enable is sampled.
  - read_valid = 1 for exactly that cycle.
  - read_data holds its value otherwise.
- FWFT mode (FWFT=1):
  - read_data = mem[rd_ptr] combinationally and read_valid = !empty.
  - read_enable acts as pop/acknowledge.
  - The first written word appears on read_data 1 cycle after its write edge.
- Wrap-around: the address wraps DEPTH-1 -> 0 with the wrap bit toggling. Ordering is preserved indefinitely.
- flush = 1:
  - At the next edge: pointers = 0, fill_count = 0, read_valid = 0, empty = 1.
  - flush wins over any write or read in the same cycle; neither is counted, and neither sets an error flag.
  - read_data holds its value in standard mode.
- clear_errors: overflow/underflow clear at the edge. If a new error occurs in the same cycle, the flag stays set (the error wins).
- Reset asserted mid-operation returns all state to reset values immediately; memory is not reset.

Decomposition:
- Package fifo_pkg holds:
  - a clog2 constant function;
  - mode constants FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1;
  - parameter legality checks (DEPTH a power of 2, AE_LEVEL < AF_LEVEL <= DEPTH).
- One sub-module, fifo_mem: DATA_WIDTH x DEPTH register array with one synchronous write port and one asynchronous read port.
- Pointer, flag, count and error logic stays in param_sync_fifo.

Test Plan:
All scenarios use DATA_WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2.
- Reset then idle -> empty=1, full=0, fill_count=0, almost_empty=1, read_data=00, overflow=underflow=0.
- Write 01..08 on consecutive cycles -> fill_count reaches 8, almost_full rises at count 6, full=1 the cycle after 08. A further write of 09 is rejected, overflow=1, fill_count stays 8.
- Standard mode: read 8 words -> read_data = 01..08 in order, each 1 cycle after read_enable, with read_valid pulsing. empty=1 after the last; a 9th read sets underflow=1 and read_data stays 08.
- FWFT mode: write AA to an empty FIFO -> read_data=AA and read_valid=1 one cycle later, with no read_enable needed. Pop -> empty=1.
- Simultaneous read+write at fill_count=4, repeated 20 cycles (crossing the wrap several times) -> fill_count stays 4 and all data comes out in order. Then flush with write_enable=1 -> fill_count=0, empty=1, no overflow.
- Async reset asserted mid-burst at fill_count=5 -> all outputs return to reset values without a clock edge. clear_errors after the overflow test -> overflow=0 next edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and elaboration-time helpers for the single-clock FIFO family.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int fifo_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic bit fifo_depth_ok(input int depth);
        return (depth >= 4) && ((depth & (depth - 1)) == 0);
    endfunction

    function automatic bit fifo_levels_ok(input int depth, input int ae_level, input int af_level);
        return (ae_level < af_level) && (af_level <= depth);
    endfunction

endpackage

// File: rtl/param_sync_fifo_if.sv
// Handshake, data and status bundle between a FIFO and its producer/consumer.
interface param_sync_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    import fifo_pkg::*;

    localparam int ADDR_W = fifo_clog2(DEPTH);

    logic                  flush;
    logic                  write_enable;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  read_enable;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  read_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_W:0]       fill_count;
    logic                  overflow;
    logic                  underflow;
    logic                  clear_errors;

    modport master (
        output flush, write_enable, write_data, read_enable, clear_errors,
        input  read_data, read_valid, full, empty, almost_full, almost_empty,
               fill_count, overflow, underflow
    );

    modport slave (
        input  flush, write_enable, write_data, read_enable, clear_errors,
        output read_data, read_valid, full, empty, almost_full, almost_empty,
               fill_count, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock parametrised FIFO with standard or first-word-fall-through read,
// threshold flags, fill count, sticky error flags and synchronous flush.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int FWFT       = FIFO_MODE_STD,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input logic               clk,
    input logic               rst,
    param_sync_fifo_if.slave  bus
);

    localparam int ADDR_W = fifo_clog2(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] AF_THRESH = (ADDR_W + 1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_THRESH = (ADDR_W + 1)'(AE_LEVEL);

    generate
        if (!fifo_depth_ok(DEPTH)) begin : g_bad_depth
            $error("param_sync_fifo: DEPTH must be a power of 2 and at least 4");
        end
        if (!fifo_levels_ok(DEPTH, AE_LEVEL, AF_LEVEL)) begin : g_bad_levels
            $error("param_sync_fifo: require AE_LEVEL < AF_LEVEL <= DEPTH");
        end
    endgenerate

    logic [ADDR_W:0]       wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W:0]       rd_ptr_reg, rd_ptr_next;
    logic [ADDR_W:0]       count_reg, count_next;
    logic                  overflow_reg, overflow_next;
    logic                  underflow_reg, underflow_next;
    logic                  full_int, empty_int;
    logic                  wr_accept, rd_accept;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    // Flags come only from registered pointers, so no enable-to-flag path exists.
    assign empty_int = (wr_ptr_reg == rd_ptr_reg);
    assign full_int  = (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]) &&
                       (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]);

    assign wr_accept = bus.write_enable && !full_int  && !bus.flush;
    assign rd_accept = bus.read_enable  && !empty_int && !bus.flush;

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        overflow_next  = overflow_reg  && !bus.clear_errors;
        underflow_next = underflow_reg && !bus.clear_errors;
        if (bus.flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (wr_accept) begin
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
            end
            if (rd_accept) begin
                rd_ptr_next = rd_ptr_reg + PTR_ONE;
            end
            if (wr_accept && !rd_accept) begin
                count_next = count_reg + PTR_ONE;
            end else if (rd_accept && !wr_accept) begin
                count_next = count_reg - PTR_ONE;
            end
            // A fresh error outranks a same-cycle clear.
            if (bus.write_enable && full_int) begin
                overflow_next = 1'b1;
            end
            if (bus.read_enable && empty_int) begin
                underflow_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr_reg[ADDR_W-1:0]),
        .wr_data (bus.write_data),
        .rd_addr (rd_ptr_reg[ADDR_W-1:0]),
        .rd_data (mem_rd_data)
    );

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            assign bus.read_data  = mem_rd_data;
            assign bus.read_valid = !empty_int;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] read_data_reg, read_data_next;
            logic                  read_valid_reg, read_valid_next;

            always_comb begin
                read_data_next  = read_data_reg;
                read_valid_next = rd_accept;
                if (rd_accept) begin
                    read_data_next = mem_rd_data;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    read_data_reg  <= '0;
                    read_valid_reg <= 1'b0;
                end else begin
                    read_data_reg  <= read_data_next;
                    read_valid_reg <= read_valid_next;
                end
            end

            assign bus.read_data  = read_data_reg;
            assign bus.read_valid = read_valid_reg;
        end
    endgenerate

    assign bus.full         = full_int;
    assign bus.empty        = empty_int;
    assign bus.fill_count   = count_reg;
    assign bus.almost_full  = (count_reg >= AF_THRESH);
    assign bus.almost_empty = (count_reg <= AE_THRESH);
    assign bus.overflow     = overflow_reg;
    assign bus.underflow    = underflow_reg;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Drives a standard-mode and an FWFT-mode FIFO with identical stimulus and
// compares both against a queue-based reference model every cycle.
module tb_param_sync_fifo;
    import fifo_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    param_sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) std_bus ();
    param_sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) fwft_bus ();

    param_sync_fifo #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(FIFO_MODE_STD), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut_std (
        .clk (clk),
        .rst (rst),
        .bus (std_bus)
    );

    param_sync_fifo #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(FIFO_MODE_FWFT), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut_fwft (
        .clk (clk),
        .rst (rst),
        .bus (fwft_bus)
    );

    // Reference model state
    logic [DW-1:0] model_q[$];
    bit            model_ov;
    bit            model_un;
    bit            model_std_valid;
    logic [DW-1:0] model_std_data;

    int check_count = 0;
    int error_count = 0;
    int txn_count   = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        model_ov        = 1'b0;
        model_un        = 1'b0;
        model_std_valid = 1'b0;
        model_std_data  = '0;
    endtask

    task automatic model_step(input bit we, input logic [DW-1:0] wd, input bit re,
                              input bit fl, input bit clr);
        bit was_full, was_empty;
        was_full  = (model_q.size() == DEPTH);
        was_empty = (model_q.size() == 0);
        model_ov  = model_ov && !clr;
        model_un  = model_un && !clr;
        if (fl) begin
            model_q.delete();
            model_std_valid = 1'b0;
        end else begin
            if (we && was_full)  model_ov = 1'b1;
            if (re && was_empty) model_un = 1'b1;
            model_std_valid = re && !was_empty;
            if (re && !was_empty) model_std_data = model_q.pop_front();
            if (we && !was_full)  model_q.push_back(wd);
        end
    endtask

    task automatic check_flags(input string who, input logic [3:0] cnt, input logic e,
                               input logic f, input logic afl, input logic ael,
                               input logic ov, input logic un);
        int n;
        n = model_q.size();
        check_value({who, "_fill_count"}, 32'(cnt), 32'(n));
        check_value({who, "_empty"}, 32'(e), 32'(n == 0));
        check_value({who, "_full"}, 32'(f), 32'(n == DEPTH));
        check_value({who, "_almost_full"}, 32'(afl), 32'(n >= AF));
        check_value({who, "_almost_empty"}, 32'(ael), 32'(n <= AE));
        check_value({who, "_overflow"}, 32'(ov), 32'(model_ov));
        check_value({who, "_underflow"}, 32'(un), 32'(model_un));
    endtask

    task automatic check_all();
        check_flags("std", std_bus.fill_count, std_bus.empty, std_bus.full,
                    std_bus.almost_full, std_bus.almost_empty, std_bus.overflow, std_bus.underflow);
        check_flags("fwft", fwft_bus.fill_count, fwft_bus.empty, fwft_bus.full,
                    fwft_bus.almost_full, fwft_bus.almost_empty, fwft_bus.overflow, fwft_bus.underflow);
        check_value("std_read_valid", 32'(std_bus.read_valid), 32'(model_std_valid));
        check_value("std_read_data", 32'(std_bus.read_data), 32'(model_std_data));
        check_value("fwft_read_valid", 32'(fwft_bus.read_valid), 32'(model_q.size() != 0));
        if (model_q.size() != 0) begin
            check_value("fwft_read_data", 32'(fwft_bus.read_data), 32'(model_q[0]));
        end
    endtask

    task automatic set_inputs(input bit we, input logic [DW-1:0] wd, input bit re,
                              input bit fl, input bit clr);
        std_bus.write_enable  = we;  fwft_bus.write_enable  = we;
        std_bus.write_data    = wd;  fwft_bus.write_data    = wd;
        std_bus.read_enable   = re;  fwft_bus.read_enable   = re;
        std_bus.flush         = fl;  fwft_bus.flush         = fl;
        std_bus.clear_errors  = clr; fwft_bus.clear_errors  = clr;
    endtask

    // One transaction: present inputs, take an edge, update model, check 1 time unit later.
    task automatic drive(input bit we, input logic [DW-1:0] wd, input bit re,
                         input bit fl, input bit clr);
        set_inputs(we, wd, re, fl, clr);
        @(posedge clk);
        model_step(we, wd, re, fl, clr);
        #1;
        txn_count++;
        $display("txn %0d: we=%0b wd=%02h re=%0b flush=%0b clr=%0b -> count=%0d std_rd=%02h/%0b fwft_rd=%02h/%0b ov=%0b un=%0b",
                 txn_count, we, wd, re, fl, clr, std_bus.fill_count, std_bus.read_data,
                 std_bus.read_valid, fwft_bus.read_data, fwft_bus.read_valid,
                 std_bus.overflow, std_bus.underflow);
        check_all();
        set_inputs(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        set_inputs(1'b0, '0, 1'b0, 1'b0, 1'b0);
        model_reset();
        rst = 1'b0;
        #12;
        check_all();
        @(negedge clk);
        rst = 1'b1;

        // Idle after reset
        repeat (2) drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check_value("reset_std_read_data", 32'(std_bus.read_data), 32'h00);

        // Fill 01..08, then overflow attempt with 09
        for (int i = 1; i <= 8; i++) drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'h09, 1'b0, 1'b0, 1'b0);
        check_value("overflow_after_09", 32'(std_bus.overflow), 32'h1);

        // clear_errors drops overflow at the next edge
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Drain 8 words, then a 9th read underflows and read_data holds 08
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
            check_value("drain_order", 32'(std_bus.read_data), 32'(i));
        end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check_value("std_hold_08", 32'(std_bus.read_data), 32'h08);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // FWFT: AA appears without read_enable, then pop
        drive(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        check_value("fwft_aa_visible", 32'(fwft_bus.read_data), 32'hAA);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Steady-state read+write at depth 4 crossing the wrap several times
        for (int i = 0; i < 4; i++) drive(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
        drive(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-burst at fill_count 5
        for (int i = 0; i < 5; i++) drive(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all();

        // Randomized traffic with biased phases to visit full and empty
        for (int i = 0; i < 400; i++) begin
            int wbias;
            wbias = ((i / 50) % 2 == 0) ? 70 : 30;
            drive($urandom_range(0, 99) < wbias, 8'($urandom),
                  $urandom_range(0, 99) < (100 - wbias),
                  $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5);
        end

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
